// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port I2C target model.
// Decodes 3-byte writes into a 16-entry 9-bit register image.
module wm8731_i2c_responder #(
   parameter logic [6:0] DEVICE_ADDR = 7'h1A,
   parameter int         NUM_REGS    = 16,
   parameter logic [6:0] RESET_REG   = 7'h0F
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       sclk,
   inout  wire        sdat,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       busy,
   output logic [7:0] err_count
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK1,
      BYTE2, ACK2, NACK, IGNORE
   } state_t;

   state_t     state, state_n;
   logic [2:0] scl_q, sda_q;
   logic [3:0] bit_cnt;
   logic [6:0] shreg;
   logic [6:0] addr_q;
   logic       d8_q;
   logic       drive_q;
   logic       armed_q;
   logic [8:0] image [NUM_REGS];

   logic       scl, sda;
   logic       scl_rise, scl_fall;
   logic       start, stop;
   logic       shifting, in_ack;
   logic       byte_done, commit, nack_inc;
   logic [7:0] byte_w;

   // Two-flop synchronizers plus a delay flop for edge detection
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], sclk};
         sda_q <= {sda_q[1:0], sdat};
      end
   end

   assign scl      = scl_q[1];
   assign sda      = sda_q[1];
   assign scl_rise = scl & ~scl_q[2];
   assign scl_fall = ~scl & scl_q[2];
   assign start    = scl & sda_q[2] & ~sda;
   assign stop     = scl & ~sda_q[2] & sda;

   // State register
   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_n;
   end

   // Next state and per-cycle event decode; START beats everything
   always_comb begin
      state_n   = state;
      shifting  = (state == ADDR) || (state == BYTE1) ||
                  (state == BYTE2) || (state == IGNORE);
      in_ack    = (state == ACK_A) || (state == ACK1) ||
                  (state == ACK2) || (state == NACK);
      byte_w    = {shreg, sda};
      byte_done = shifting && scl_rise && (bit_cnt == 4'd7) &&
                  !start && !stop;
      commit    = byte_done && (state == BYTE2);
      nack_inc  = byte_done && ((state == IGNORE) ||
                  ((state == ADDR) &&
                   (byte_w != {DEVICE_ADDR, 1'b0})));
      case (state)
         ADDR:
            if (byte_done)
               state_n = (byte_w == {DEVICE_ADDR, 1'b0}) ?
                         ACK_A : NACK;
         BYTE1:   if (byte_done) state_n = ACK1;
         BYTE2:   if (byte_done) state_n = ACK2;
         IGNORE:  if (byte_done) state_n = NACK;
         ACK_A:   if (scl_fall && armed_q) state_n = BYTE1;
         ACK1:    if (scl_fall && armed_q) state_n = BYTE2;
         ACK2:    if (scl_fall && armed_q) state_n = IGNORE;
         NACK:    if (scl_fall && armed_q) state_n = IGNORE;
         default: state_n = state;
      endcase
      if (stop)  state_n = IDLE;
      if (start) state_n = ADDR;
   end

   // Shifting, ACK drive window, commit latch and NACK counting
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         addr_q    <= '0;
         d8_q      <= 1'b0;
         drive_q   <= 1'b0;
         armed_q   <= 1'b0;
         busy      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         err_count <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (start || stop) begin
            bit_cnt <= '0;
            drive_q <= 1'b0;
            armed_q <= 1'b0;
            busy    <= start;
         end else begin
            if (shifting && scl_rise) begin
               shreg   <= byte_w[6:0];
               bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            end
            if (in_ack && scl_fall) begin
               armed_q <= ~armed_q;
               drive_q <= ~armed_q && (state != NACK);
            end
            if (byte_done && (state == BYTE1)) begin
               addr_q <= byte_w[7:1];
               d8_q   <= byte_w[0];
            end
            if (commit) begin
               wr_valid <= 1'b1;
               wr_addr  <= addr_q;
               wr_data  <= {d8_q, byte_w};
            end
            if (nack_inc && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end
      end
   end

   // Register image; RESET_REG clears it, out-of-range is dropped
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < NUM_REGS; i++) image[i] <= '0;
      end else if (commit) begin
         if (addr_q == RESET_REG) begin
            for (int i = 0; i < NUM_REGS; i++) image[i] <= '0;
         end else if (int'(addr_q) < NUM_REGS) begin
            image[addr_q[3:0]] <= {d8_q, byte_w};
         end
      end
   end

   assign rd_data = image[rd_addr];
   assign sdat    = (drive_q && !reset_reset) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for wm8731_i2c_responder: bit-banged I2C master,
// table vectors, write scoreboard and corner sequences.
module tb_wm8731_i2c_responder;

   localparam int Q = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   wire        sdat;
   logic [3:0] rd_addr = '0;
   logic [8:0] rd_data;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       busy;
   logic [7:0] err_count;

   int n_vec = 0;
   int n_miss = 0;
   int drive_cnt = 0;
   int exp_err = 0;

   typedef struct packed {
      logic [6:0] a;
      logic [8:0] d;
   } wr_t;
   wr_t sbq[$];

   typedef struct {
      int          nb;
      logic [31:0] bytes;
      logic [3:0]  ack;
      int          errd;
      logic        cm;
      logic [6:0]  wa;
      logic [8:0]  wd;
      logic [3:0]  ri;
      logic [8:0]  re;
   } vec_t;
   vec_t vt[7];

   pullup (sdat);
   assign sdat = m_sda ? 1'bz : 1'b0;

   always #5 clk = ~clk;

   wm8731_i2c_responder dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .sclk        (m_scl),
      .sdat        (sdat),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .err_count   (err_count)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every committed write must match the queue head
   always @(negedge clk) begin
      wr_t e;
      if (!rst && wr_valid) begin
         if (sbq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_wr: got %0h/%0h expected none",
                     wr_addr, wr_data);
         end else begin
            e = sbq.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e.a));
            chk("wr_data", 32'(wr_data), 32'(e.d));
         end
      end
   end

   // Counts cycles where the responder pulls the line low
   always @(negedge clk) begin
      if (m_sda && sdat === 1'b0) drive_cnt++;
   end

   task automatic i2c_start();
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b1; #Q;
      #Q;
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;    #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b,
                            output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      acked = (sdat === 1'b0);
      #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic rd_chk(input string nm,
                         input logic [3:0] idx,
                         input logic [8:0] exp);
      rd_addr = idx;
      #1;
      chk(nm, 32'(rd_data), 32'(exp));
   endtask

   task automatic do_write(input logic [7:0] b1,
                           input logic [7:0] b2);
      logic a;
      i2c_start();
      send_byte(8'h34, a); chk("wack0", 32'(a), 1);
      send_byte(b1, a);    chk("wack1", 32'(a), 1);
      send_byte(b2, a);    chk("wack2", 32'(a), 1);
      i2c_stop();
   endtask

   initial begin
      logic a;
      int   d0;
      logic [7:0] rb;

      vt[0] = '{3, 32'h34081200, 4'b0111, 0, 1'b1,
                7'h04, 9'h012, 4'd4, 9'h012};
      vt[1] = '{3, 32'h36081200, 4'b0000, 3, 1'b0,
                7'h00, 9'h000, 4'd4, 9'h012};
      vt[2] = '{1, 32'h35000000, 4'b0000, 1, 1'b0,
                7'h00, 9'h000, 4'd4, 9'h012};
      vt[3] = '{4, 32'h340F3F01, 4'b0111, 1, 1'b1,
                7'h07, 9'h13F, 4'd7, 9'h13F};
      vt[4] = '{3, 32'h3440AA00, 4'b0111, 0, 1'b1,
                7'h20, 9'h0AA, 4'd4, 9'h012};
      vt[5] = '{3, 32'h34200100, 4'b0111, 0, 1'b1,
                7'h10, 9'h001, 4'd0, 9'h000};
      vt[6] = '{3, 32'h341DFF00, 4'b0111, 0, 1'b1,
                7'h0E, 9'h1FF, 4'd14, 9'h1FF};

      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_count), 0);
      chk("rst_wr_valid", 32'(wr_valid), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_sdat", 32'(sdat), 1);
      rd_chk("rst_rd4", 4'd4, 9'h000);

      for (int v = 0; v < 7; v++) begin
         if (vt[v].cm) sbq.push_back({vt[v].wa, vt[v].wd});
         d0 = drive_cnt;
         i2c_start();
         chk($sformatf("busy_start v%0d", v), 32'(busy), 1);
         for (int b = 0; b < vt[v].nb; b++) begin
            rb = vt[v].bytes[31-8*b -: 8];
            send_byte(rb, a);
            chk($sformatf("ack v%0d b%0d", v, b),
                32'(a), 32'(vt[v].ack[b]));
         end
         i2c_stop();
         exp_err += vt[v].errd;
         chk($sformatf("err v%0d", v), 32'(err_count), exp_err);
         chk($sformatf("busy_stop v%0d", v), 32'(busy), 0);
         chk($sformatf("sb_empty v%0d", v), sbq.size(), 0);
         rd_chk($sformatf("rd v%0d", v), vt[v].ri, vt[v].re);
         if (vt[v].ack == 4'b0000)
            chk($sformatf("no_drive v%0d", v), drive_cnt - d0, 0);
      end

      // Partial word cut by repeated START, then RESET_REG write
      sbq.push_back({7'h02, 9'h055});
      do_write(8'h04, 8'h55);
      rd_chk("rd2_pre", 4'd2, 9'h055);
      sbq.push_back({7'h0F, 9'h000});
      i2c_start();
      send_byte(8'h34, a);
      chk("rs_ack0", 32'(a), 1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      i2c_start();
      chk("rs_busy", 32'(busy), 1);
      send_byte(8'h34, a); chk("rs_ack1", 32'(a), 1);
      send_byte(8'h1E, a); chk("rs_ack2", 32'(a), 1);
      send_byte(8'h00, a); chk("rs_ack3", 32'(a), 1);
      i2c_stop();
      chk("rs_sb_empty", sbq.size(), 0);
      chk("rs_err", 32'(err_count), exp_err);
      rd_chk("rd2_clr", 4'd2, 9'h000);
      rd_chk("rd7_clr", 4'd7, 9'h000);
      rd_chk("rd14_clr", 4'd14, 9'h000);

      // Reset while the BYTE1 ACK is being driven
      i2c_start();
      send_byte(8'h34, a);
      chk("ra_ack0", 32'(a), 1);
      rb = 8'h0D;
      for (int i = 7; i >= 1; i--) send_bit(rb[i]);
      m_sda = rb[0]; #Q;
      m_scl = 1'b1;  #(2*Q);
      m_scl = 1'b0;
      m_sda = 1'b1;
      #50;
      chk("ack_latency", 32'(sdat), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_release", 32'(sdat), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_err", 32'(err_count), 0);
      exp_err = 0;
      rst = 1'b0;
      #Q;
      m_scl = 1'b1;
      #(2*Q);
      sbq.push_back({7'h03, 9'h0A5});
      do_write(8'h06, 8'hA5);
      chk("post_rst_sb", sbq.size(), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_err", 32'(err_count), exp_err);
      rd_chk("rd3_post", 4'd3, 9'h0A5);

      repeat (20) @(negedge clk);
      chk("final_sb_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

endmodule
